rsa_cmd_ctrl: RTL

RSA_CMD_CTRL -- requirements
Module: rsa_cmd_ctrl

---
 rtl/rsa_cmd_ctrl_if.sv | 38 +++
 rtl/rsa_cmd_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rsa_cmd_ctrl_if.sv
// rsa_cmd_ctrl_if -- bundle of every non-clock/reset signal of the RSA command
// controller: the host CSR word pair, the inbound/outbound DMA handshakes, the
// exponentiator handshake and the operand/result registers.
//   slave  : the controller side (drives status, start pulses and operands)
//   master : the host/DMA/exponentiator side
interface rsa_cmd_ctrl_if #(
  parameter int DATA_W = 1024
);
  logic [31:0]       cmd_word;
  logic [31:0]       status_word;
  logic              dma_rx_start;
  logic              dma_rx_done;
  logic [DATA_W-1:0] dma_rx_data;
  logic              dma_tx_start;
  logic              dma_tx_done;
  logic [DATA_W-1:0] dma_tx_data;
  logic              exp_start;
  logic              exp_decrypt;
  logic              exp_done;
  logic [DATA_W-1:0] exp_result;
  logic [DATA_W-1:0] op_n;
  logic [DATA_W-1:0] op_rmodn;
  logic [DATA_W-1:0] op_m;
  logic [DATA_W-1:0] op_r2modn;
  logic [DATA_W-1:0] op_e;

  modport slave (
    input  cmd_word, dma_rx_done, dma_rx_data, dma_tx_done, exp_done, exp_result,
    output status_word, dma_rx_start, dma_tx_start, dma_tx_data, exp_start,
           exp_decrypt, op_n, op_rmodn, op_m, op_r2modn, op_e
  );

  modport master (
    output cmd_word, dma_rx_done, dma_rx_data, dma_tx_done, exp_done, exp_result,
    input  status_word, dma_rx_start, dma_tx_start, dma_tx_data, exp_start,
           exp_decrypt, op_n, op_rmodn, op_m, op_r2modn, op_e
  );
endinterface

// File: rtl/rsa_cmd_ctrl.sv
// rsa_cmd_ctrl -- command sequencer for an RSA accelerator.
// Decodes the host COMMAND word, loads operands through inbound DMA, launches
// the modular exponentiator, hands the result to outbound DMA and reports
// progress through the status word.
// Ports:
//   clk    : rising-edge clock for all state
//   resetn : synchronous active-low reset
//   bus    : rsa_cmd_ctrl_if.slave (CSR words, DMA, exponentiator, operands)
module rsa_cmd_ctrl #(
  parameter int DATA_W = 1024
) (
  input  logic          clk,
  input  logic          resetn,
  rsa_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_WAIT = 3'd1,
    RX_DMA  = 3'd2,
    EXP     = 3'd3,
    TX_WAIT = 3'd4,
    TX_DMA  = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [2:0] I_COMP      = 3'd1;
  localparam logic [2:0] I_READ_IN   = 3'd2;
  localparam logic [2:0] I_WRITE_OUT = 3'd3;
  localparam logic [2:0] I_ENCRYPT   = 3'd4;
  localparam logic [2:0] I_DECRYPT   = 3'd5;

  // Command word fields
  logic [2:0] instr;
  logic       in_data_valid, in_done_ack, in_cmd_valid, in_data_ready, in_param_valid;
  logic [2:0] param_cnt;

  assign instr          = bus.cmd_word[2:0];
  assign in_data_valid  = bus.cmd_word[3];
  assign in_done_ack    = bus.cmd_word[7];
  assign in_cmd_valid   = bus.cmd_word[8];
  assign in_data_ready  = bus.cmd_word[9];
  assign param_cnt      = bus.cmd_word[16:14];
  assign in_param_valid = bus.cmd_word[17];

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{bus.cmd_word[31:18], bus.cmd_word[13:10], bus.cmd_word[6:4]};

  state_t            state;
  logic [2:0]        param_sel;
  logic [2:0]        last_instr;
  logic              armed;
  logic              out_tx_ready, out_data_ready, out_is_done, out_param_ready, out_cmd_ready;
  logic              rx_start, tx_start, ex_start, ex_decrypt;
  logic [DATA_W-1:0] op_n, op_rmodn, op_m, op_r2modn, op_e, result;

  logic instr_ok;
  logic accept;

  assign instr_ok = (instr >= I_COMP) && (instr <= I_DECRYPT);
  // armed is the registered edge-detector: a command held valid with the same
  // code is executed only once.
  assign accept   = (state == IDLE) && in_cmd_valid && armed && instr_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      param_sel       <= 3'd0;
      last_instr      <= 3'd0;
      armed           <= 1'b0;
      out_tx_ready    <= 1'b0;
      out_data_ready  <= 1'b0;
      out_is_done     <= 1'b0;
      out_param_ready <= 1'b0;
      out_cmd_ready   <= 1'b0;
      rx_start        <= 1'b0;
      tx_start        <= 1'b0;
      ex_start        <= 1'b0;
      ex_decrypt      <= 1'b0;
      op_n            <= '0;
      op_rmodn        <= '0;
      op_m            <= '0;
      op_r2modn       <= '0;
      op_e            <= '0;
      result          <= '0;
    end else begin
      rx_start <= 1'b0;
      tx_start <= 1'b0;
      ex_start <= 1'b0;

      // Level-held status bits drop as soon as the host withdraws its request.
      if (!in_data_valid) out_data_ready <= 1'b0;
      if (!in_data_ready) out_tx_ready   <= 1'b0;

      if (accept)
        armed <= 1'b0;
      else if (!in_cmd_valid || (instr != last_instr))
        armed <= 1'b1;

      if (accept)
        out_cmd_ready <= 1'b1;
      else if (!in_cmd_valid || ((state == DONE) && in_done_ack))
        out_cmd_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (in_param_valid) param_sel <= param_cnt;
          out_param_ready <= in_param_valid;
          if (accept) begin
            last_instr <= instr;
            case (instr)
              I_COMP: begin
                state       <= DONE;
                out_is_done <= 1'b1;
              end
              I_READ_IN:   state <= RX_WAIT;
              I_WRITE_OUT: state <= TX_WAIT;
              I_ENCRYPT, I_DECRYPT: begin
                state      <= EXP;
                ex_start   <= 1'b1;
                ex_decrypt <= (instr == I_DECRYPT);
              end
              default: state <= IDLE;
            endcase
          end
        end
        RX_WAIT: begin
          if (in_data_valid) begin
            out_data_ready <= 1'b1;
            rx_start       <= 1'b1;
            state          <= RX_DMA;
          end
        end
        RX_DMA: begin
          if (bus.dma_rx_done) begin
            // Selectors 5-7 name no operand: the word is dropped.
            case (param_sel)
              3'd0:    op_n      <= bus.dma_rx_data;
              3'd1:    op_rmodn  <= bus.dma_rx_data;
              3'd2:    op_m      <= bus.dma_rx_data;
              3'd3:    op_r2modn <= bus.dma_rx_data;
              3'd4:    op_e      <= bus.dma_rx_data;
              default: op_n      <= op_n;
            endcase
            out_is_done <= 1'b1;
            state       <= DONE;
          end
        end
        EXP: begin
          if (bus.exp_done) begin
            result      <= bus.exp_result;
            out_is_done <= 1'b1;
            state       <= DONE;
          end
        end
        TX_WAIT: begin
          if (in_data_ready) begin
            tx_start <= 1'b1;
            state    <= TX_DMA;
          end
        end
        TX_DMA: begin
          if (bus.dma_tx_done) begin
            out_tx_ready <= 1'b1;
            out_is_done  <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (in_done_ack) begin
            out_is_done <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.status_word  = {12'b0, out_cmd_ready, out_param_ready, 11'b0,
                             out_is_done, out_data_ready, out_tx_ready, 4'b0};
  assign bus.dma_rx_start = rx_start;
  assign bus.dma_tx_start = tx_start;
  assign bus.exp_start    = ex_start;
  assign bus.exp_decrypt  = ex_decrypt;
  assign bus.dma_tx_data  = result;
  assign bus.op_n         = op_n;
  assign bus.op_rmodn     = op_rmodn;
  assign bus.op_m         = op_m;
  assign bus.op_r2modn    = op_r2modn;
  assign bus.op_e         = op_e;

endmodule
